// File: rtl/line_drawer.sv
// line_drawer: Bresenham rasteriser emitting on-screen pixels of one segment per start pulse.
module line_drawer #(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        ready,
   input  logic [15:0] x1,
   input  logic [15:0] y1,
   input  logic [15:0] x2,
   input  logic [15:0] y2,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic [15:0] pixel_x,
   output logic [15:0] pixel_y
);
   typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;
   state_t state, state_nx;
   logic signed [17:0] dx, dy, err, xd, yd;
   logic signed [18:0] e2;
   logic [15:0] cx, cy, ex, ey;
   logic sxn, syn, in_screen, consume, at_end, step_x, step_y;

   always_comb begin
      xd        = $signed({2'b0, x2}) - $signed({2'b0, x1});
      yd        = $signed({2'b0, y2}) - $signed({2'b0, y1});
      in_screen = (32'(cx) < SCREEN_WIDTH) && (32'(cy) < SCREEN_HEIGHT);
      consume   = (state == DRAW) && (!in_screen || pixel_ready);
      at_end    = (cx == ex) && (cy == ey);
      e2        = {err, 1'b0};
      step_x    = e2 >= 19'(dy);
      step_y    = e2 <= 19'(dx);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = (state == IDLE && start) ? LOAD :
                 (state == LOAD) ? DRAW :
                 (consume && at_end) ? IDLE : state;
   end

   always_comb begin
      ready       = state == IDLE;
      pixel_valid = (state == DRAW) && in_screen;
      pixel_x     = cx;
      pixel_y     = cy;
   end

   // Coordinates are taken in LOAD, not at start, as upstream is still settling y2 then.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {cx, cy, ex, ey} <= '0;
         {dx, dy, err}    <= '0;
         {sxn, syn}       <= '0;
      end else if (state == LOAD) begin
         cx  <= x1;
         cy  <= y1;
         ex  <= x2;
         ey  <= y2;
         dx  <= xd[17] ? -xd : xd;
         dy  <= yd[17] ? yd : -yd;
         err <= (xd[17] ? -xd : xd) + (yd[17] ? yd : -yd);
         sxn <= !(x1 < x2);
         syn <= !(y1 < y2);
      end else if (consume && !at_end) begin
         err <= err + (step_x ? dy : 18'sd0) + (step_y ? dx : 18'sd0);
         cx  <= cx + (step_x ? (sxn ? 16'hffff : 16'd1) : 16'd0);
         cy  <= cy + (step_y ? (syn ? 16'hffff : 16'd1) : 16'd0);
      end
   end
endmodule

// File: tb/tb_line_drawer.sv
// tb_line_drawer: directed tests with a pixel scoreboard for line_drawer.
module tb_line_drawer;
   logic clk = 0, rst = 1, start = 0, ready, pixel_valid, pixel_ready = 1;
   logic [15:0] x1 = 0, y1 = 0, x2 = 0, y2 = 0, pixel_x, pixel_y;
   logic [31:0] q[$];
   int n_chk = 0, n_fail = 0, busy;
   logic prev_stall = 0;
   logic [31:0] prev_pix = 0;

   line_drawer dut (.clk(clk), .rst(rst), .start(start), .ready(ready),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2), .pixel_valid(pixel_valid),
      .pixel_ready(pixel_ready), .pixel_x(pixel_x), .pixel_y(pixel_y));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard pop on every handshake, plus hold-while-stalled checks.
   always @(negedge clk) begin
      if (prev_stall) begin
         check("stall_valid", 32'(pixel_valid), 32'd1);
         check("stall_hold", {pixel_x, pixel_y}, prev_pix);
      end
      if (pixel_valid && pixel_ready) begin
         if (q.size() == 0) check("unexpected_pixel", {pixel_x, pixel_y}, 32'hffffffff);
         else check("pixel", {pixel_x, pixel_y}, q.pop_front());
      end
      prev_stall = pixel_valid && !pixel_ready;
      prev_pix   = {pixel_x, pixel_y};
   end

   task automatic line(input logic [15:0] a, b, c, d, input logic tog, output int nb);
      logic done = 0;
      int k = 0;
      @(posedge clk); #1;
      x1 = a; y1 = b; x2 = c; y2 = d; start = 1;
      @(posedge clk); #1;
      start = 0;
      nb = 0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         if (i == 0) check("load_valid", 32'(pixel_valid), 32'd0);
         if (i == 1) check("first_valid", 32'(pixel_valid), 32'(a < 640 && b < 480));
         if (ready) done = 1;
         else begin
            nb++;
            @(posedge clk); #1;
            k++;
            pixel_ready = tog ? (k % 3 == 0) : 1'b1;
         end
      end
      pixel_ready = 1;
      check("ready_timeout", 32'(done), 32'd1);
      check("queue_drained", 32'(q.size()), 32'd0);
   endtask

   initial begin
      #2;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_valid", 32'(pixel_valid), 32'd0);
      check("rst_xy", {pixel_x, pixel_y}, 32'd0);
      @(posedge clk); #1 rst = 0;
      for (int i = 0; i < 4; i++) q.push_back({16'(i), 16'd0});
      line(0, 0, 3, 0, 0, busy);
      check("busy_horiz", 32'(busy), 32'd5);
      q.push_back({16'd2, 16'd4}); q.push_back({16'd1, 16'd3}); q.push_back({16'd1, 16'd2});
      q.push_back({16'd0, 16'd1}); q.push_back({16'd0, 16'd0});
      line(2, 4, 0, 0, 0, busy);
      check("busy_steep", 32'(busy), 32'd6);
      q.push_back({16'd5, 16'd5});
      line(5, 5, 5, 5, 0, busy);
      check("busy_point", 32'(busy), 32'd2);
      for (int i = 0; i < 4; i++) q.push_back({16'(i), 16'(i)});
      line(0, 0, 3, 3, 1, busy);
      q.push_back({16'd638, 16'd0}); q.push_back({16'd639, 16'd0});
      line(638, 0, 641, 0, 0, busy);
      check("busy_clip", 32'(busy), 32'd5);
      // Reset in the middle of a line, with an ignored start while busy.
      q.push_back({16'd0, 16'd0}); q.push_back({16'd1, 16'd0});
      @(posedge clk); #1;
      x1 = 0; y1 = 0; x2 = 9; y2 = 0; start = 1;
      @(posedge clk); #1 start = 0;
      @(posedge clk); #1;
      start = 1; x1 = 100; y1 = 100; x2 = 100; y2 = 100;
      @(posedge clk); #1 start = 0;
      @(posedge clk); #1;
      check("pre_rst_busy", 32'(ready), 32'd0);
      check("pre_rst_drained", 32'(q.size()), 32'd0);
      rst = 1;
      #1;
      check("midrst_valid", 32'(pixel_valid), 32'd0);
      check("midrst_ready", 32'(ready), 32'd1);
      @(posedge clk); #1 rst = 0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("post_rst_valid", 32'(pixel_valid), 32'd0);
      check("post_rst_ready", 32'(ready), 32'd1);
      check("final_queue", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
